// File: rtl/smoldvi_line_doubler_pkg.sv
// Shared pixel definitions for the smoldvi video path: RGB565 field layout,
// read-side FSM states, and the component width conversion.
package smoldvi_line_doubler_pkg;

    localparam int PIX_W  = 16;
    localparam int R_LSB  = 11;
    localparam int R_W    = 5;
    localparam int G_LSB  = 5;
    localparam int G_W    = 6;
    localparam int B_LSB  = 0;
    localparam int B_W    = 5;
    localparam int MAX_RGB_BITS = 7;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_LOAD,
        RD_PLAY,
        RD_STARVE
    } rd_state_t;

    // Widen a 5-bit component to 7 bits by MSB replication, then keep the top
    // 'bits' bits, right-aligned in the result.
    function automatic logic [MAX_RGB_BITS-1:0] expand_c5(input logic [R_W-1:0] c, input int bits);
        logic [MAX_RGB_BITS-1:0] wide;
        wide = {c, c[4:3]};
        return wide >> (MAX_RGB_BITS - bits);
    endfunction

    function automatic logic [MAX_RGB_BITS-1:0] expand_g6(input logic [G_W-1:0] c, input int bits);
        logic [MAX_RGB_BITS-1:0] wide;
        wide = {c, c[5]};
        return wide >> (MAX_RGB_BITS - bits);
    endfunction

endpackage

// File: rtl/smoldvi_line_doubler_ram.sv
// Two-bank line store: one write port, one registered read port with enable.
// The read register doubles as the prefetch stage for the output pixel.
module smoldvi_line_doubler_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/smoldvi_line_doubler.sv
// Ping-pong line buffer that replays each stored RGB565 line twice, one pixel
// per rgb_rdy strobe, giving 2x vertical doubling ahead of the DVI stage.
module smoldvi_line_doubler #(
    parameter int LINE_PIXELS = 320,
    parameter int RGB_BITS    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         in_data,
    input  logic                rgb_rdy,
    output logic [RGB_BITS-1:0] r,
    output logic [RGB_BITS-1:0] g,
    output logic [RGB_BITS-1:0] b,
    output logic                underflow,
    input  logic                underflow_clr
);
    import smoldvi_line_doubler_pkg::*;

    localparam int PTR_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(LINE_PIXELS - 1);
    localparam logic [PTR_W-1:0] PENULT = PTR_W'(LINE_PIXELS - 2);
    localparam logic [PTR_W-1:0] ZERO   = '0;

    logic [1:0]       full;
    logic             wbank, rbank, pass, pass_nxt, rbank_nxt;
    logic [PTR_W-1:0] wptr, rptr, rptr_nxt, scnt, scnt_nxt;
    logic             accept, wr_last;
    logic             rd_en, load_out, zero_out, full_clr, uf_set;
    logic [PTR_W:0]   rd_addr;
    logic [15:0]      rd_data;
    logic [RGB_BITS-1:0] r_conv, g_conv, b_conv;
    rd_state_t        state, state_nxt;

    assign in_ready = !full[wbank];
    assign accept   = in_valid && in_ready;
    assign wr_last  = accept && (wptr == LAST);

    smoldvi_line_doubler_ram #(.ADDR_W(PTR_W + 1), .DATA_W(PIX_W)) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr ({wbank, wptr}),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            wbank <= 1'b0;
        end else if (accept) begin
            wptr  <= wr_last ? '0 : wptr + 1'b1;
            wbank <= wr_last ? !wbank : wbank;
        end
    end

    // Reader clears rbank, writer sets wbank; they never collide on one bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
        end else begin
            if (full_clr)
                full[rbank] <= 1'b0;
            if (wr_last)
                full[wbank] <= 1'b1;
        end
    end

    // rptr indexes the pixel on r/g/b; rd_data already holds the next one.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = {rbank, ZERO};
        load_out  = 1'b0;
        zero_out  = 1'b0;
        full_clr  = 1'b0;
        uf_set    = 1'b0;
        rptr_nxt  = rptr;
        pass_nxt  = pass;
        rbank_nxt = rbank;
        scnt_nxt  = scnt;
        case (state)
            RD_IDLE: begin
                if (full[rbank]) begin
                    rd_en     = 1'b1;
                    state_nxt = RD_LOAD;
                end
            end
            RD_LOAD: begin
                load_out  = 1'b1;
                rd_en     = 1'b1;
                rd_addr   = {rbank, PTR_W'(1)};
                rptr_nxt  = '0;
                state_nxt = RD_PLAY;
            end
            RD_PLAY: begin
                if (rgb_rdy) begin
                    if (rptr == LAST) begin
                        rptr_nxt = '0;
                        pass_nxt = !pass;
                        if (!pass) begin
                            load_out = 1'b1;
                            rd_en    = 1'b1;
                            rd_addr  = {rbank, PTR_W'(1)};
                        end else begin
                            full_clr  = 1'b1;
                            rbank_nxt = !rbank;
                            if (full[!rbank]) begin
                                load_out = 1'b1;
                                rd_en    = 1'b1;
                                rd_addr  = {!rbank, PTR_W'(1)};
                            end else begin
                                zero_out  = 1'b1;
                                uf_set    = 1'b1;
                                scnt_nxt  = '0;
                                state_nxt = RD_STARVE;
                            end
                        end
                    end else begin
                        load_out = 1'b1;
                        rd_en    = 1'b1;
                        rptr_nxt = rptr + 1'b1;
                        // Fetch pixel 0 of whichever line follows, so the seam has no gap.
                        if (rptr == PENULT)
                            rd_addr = {(pass ? !rbank : rbank), ZERO};
                        else
                            rd_addr = {rbank, rptr + PTR_W'(2)};
                    end
                end
            end
            RD_STARVE: begin
                rd_en = 1'b1;
                if (rgb_rdy) begin
                    if (scnt == LAST) begin
                        scnt_nxt = '0;
                        if (full[rbank]) begin
                            load_out  = 1'b1;
                            rd_addr   = {rbank, PTR_W'(1)};
                            rptr_nxt  = '0;
                            pass_nxt  = 1'b0;
                            state_nxt = RD_PLAY;
                        end else begin
                            uf_set = 1'b1;
                        end
                    end else begin
                        scnt_nxt = scnt + 1'b1;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
            rptr  <= '0;
            pass  <= 1'b0;
            rbank <= 1'b0;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            rptr  <= rptr_nxt;
            pass  <= pass_nxt;
            rbank <= rbank_nxt;
            scnt  <= scnt_nxt;
        end
    end

    assign r_conv = RGB_BITS'(expand_c5(rd_data[R_LSB +: R_W], RGB_BITS));
    assign g_conv = RGB_BITS'(expand_g6(rd_data[G_LSB +: G_W], RGB_BITS));
    assign b_conv = RGB_BITS'(expand_c5(rd_data[B_LSB +: B_W], RGB_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (load_out) begin
            r <= r_conv;
            g <= g_conv;
            b <= b_conv;
        end else if (zero_out) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underflow <= 1'b0;
        else if (uf_set)
            underflow <= 1'b1;
        else if (underflow_clr)
            underflow <= 1'b0;
    end

endmodule

// File: tb/tb_smoldvi_line_doubler.sv
// Scoreboard bench for smoldvi_line_doubler with 4-pixel lines; a second
// instance at RGB_BITS=7 shares the stimulus for the width check.
module tb_smoldvi_line_doubler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        rgb_rdy = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        in_ready, underflow;
    logic [5:0]  r, g, b;
    logic        ready7, underflow7;
    logic [6:0]  r7, g7, b7;

    int checks = 0;
    int errors = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    smoldvi_line_doubler #(.LINE_PIXELS(4), .RGB_BITS(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rgb_rdy(rgb_rdy), .r(r), .g(g), .b(b),
        .underflow(underflow), .underflow_clr(underflow_clr)
    );

    smoldvi_line_doubler #(.LINE_PIXELS(4), .RGB_BITS(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready7),
        .in_data(in_data), .rgb_rdy(rgb_rdy), .r(r7), .g(g7), .b(b7),
        .underflow(underflow7), .underflow_clr(underflow_clr)
    );

    // Reference RGB565 -> 6-bit conversion: R/B get their MSB appended, G passes through.
    function automatic logic [17:0] px6(input logic [15:0] p);
        return {p[15:11], p[15], p[10:5], p[4:0], p[4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rdy();
        rgb_rdy = 1'b1;
        step();
        rgb_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        rgb_rdy = 1'b0;
        underflow_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_q.delete();
    endtask

    // Writes one line and queues its two expected replays.
    task automatic write_line(input logic [15:0] px [4]);
        int waited;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = px[i];
            waited = 0;
            while (!in_ready && waited < 64) begin
                step();
                waited++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL write_timeout: in_ready=%0b required 1 within 64 cycles", in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(px6(px[i]));
    endtask

    task automatic test_reset();
        logic [15:0] la [4];
        logic [17:0] exp;
        la = '{16'hFFFF, 16'h1234, 16'h5678, 16'h9ABC};
        do_reset();
        checks++;
        if ({r, g, b} !== 18'h0 || underflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: rgb=%h uf=%b rdy=%b required rgb=0 uf=0 rdy=1", {r, g, b}, underflow, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            pulse_rdy();
            checks++;
            if ({r, g, b} !== 18'h0) begin
                errors++;
                $display("FAIL reset_idle_rdy: rgb=%h required 0", {r, g, b});
            end
            step();
        end
        write_line(la);
        step();
        step();
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL reset_prefill: rgb=%h required %h", {r, g, b}, exp);
        end
        in_valid = 1'b1;
        in_data = 16'hAAAA;
        step();
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        step();
        exp_q.delete();
        checks++;
        if ({r, g, b} !== 18'h0 || underflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midline: rgb=%h uf=%b rdy=%b required rgb=0 uf=0 rdy=1", {r, g, b}, underflow, in_ready);
        end
        rst_n = 1'b1;
        step();
        la = '{16'h07E0, 16'h001F, 16'hF800, 16'h0000};
        write_line(la);
        step();
        step();
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL reset_discard_partial: rgb=%h required %h", {r, g, b}, exp);
        end
    endtask

    task automatic test_basic_doubling();
        logic [15:0] la [4];
        logic [15:0] lb [4];
        logic [17:0] exp;
        la = '{16'h0000, 16'hF800, 16'h07E0, 16'h001F};
        lb = '{16'hFFFF, 16'h8410, 16'h4208, 16'hA5A5};
        do_reset();
        write_line(la);
        step();
        step();
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL basic_first_pixel: rgb=%h required %h", {r, g, b}, exp);
        end
        write_line(lb);
        exp_q.push_back(18'h0);
        for (int p = 1; p <= 16; p++) begin
            pulse_rdy();
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL basic_pulse%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
            step();
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL basic_hold%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] la [4];
        logic [15:0] lb [4];
        logic [15:0] lc [4];
        logic [17:0] exp;
        la = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        lb = '{16'h5555, 16'h6666, 16'h7777, 16'h8888};
        lc = '{16'h9999, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        do_reset();
        write_line(la);
        write_line(lb);
        in_valid = 1'b1;
        in_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_ready_low%0d: in_ready=%b required 0", i, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL bp_first_pixel: rgb=%h required %h", {r, g, b}, exp);
        end
        for (int p = 1; p <= 8; p++) begin
            if (p == 8) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_before_release: in_ready=%b required 0", in_ready);
                end
            end
            pulse_rdy();
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL bp_pulse%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
            step();
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b required 1", in_ready);
        end
        write_line(lc);
        exp_q.push_back(18'h0);
        for (int p = 9; p <= 24; p++) begin
            pulse_rdy();
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL bp_pulse%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
            step();
        end
    endtask

    task automatic test_underflow();
        logic [15:0] la [4];
        logic [15:0] lc [4];
        logic [17:0] exp;
        la = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
        lc = '{16'h0841, 16'hF81F, 16'h07FF, 16'hFFE0};
        do_reset();
        write_line(la);
        for (int i = 0; i < 4; i++)
            exp_q.push_back(18'h0);
        step();
        step();
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL uf_first_pixel: rgb=%h required %h", {r, g, b}, exp);
        end
        for (int p = 1; p <= 15; p++) begin
            pulse_rdy();
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL uf_pulse%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
            if (p == 7 || p == 8) begin
                checks++;
                if (underflow !== (p == 8)) begin
                    errors++;
                    $display("FAIL uf_flag_pulse%0d: underflow=%b required %b", p, underflow, (p == 8));
                end
            end
            step();
            if (p == 9)
                write_line(lc);
        end
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_clear: underflow=%b required 0", underflow);
        end
    endtask

    task automatic test_clear_race();
        logic [15:0] la [4];
        logic [17:0] exp;
        la = '{16'h1F00, 16'h00F8, 16'hE007, 16'h7BEF};
        do_reset();
        write_line(la);
        exp_q.push_back(18'h0);
        step();
        step();
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL race_first_pixel: rgb=%h required %h", {r, g, b}, exp);
        end
        for (int p = 1; p <= 8; p++) begin
            underflow_clr = (p == 8);
            pulse_rdy();
            underflow_clr = 1'b0;
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 18'bx;
            checks++;
            if ({r, g, b} !== exp) begin
                errors++;
                $display("FAIL race_pulse%0d: rgb=%h required %h", p, {r, g, b}, exp);
            end
            step();
        end
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL race_set_wins: underflow=%b required 1", underflow);
        end
    endtask

    task automatic test_width();
        logic [15:0] la [4];
        logic [17:0] exp;
        la = '{16'h8410, 16'h8410, 16'h8410, 16'h8410};
        do_reset();
        write_line(la);
        step();
        step();
        checks++;
        if ({r7, g7, b7} !== {7'h42, 7'h41, 7'h42}) begin
            errors++;
            $display("FAIL width7: rgb=%h/%h/%h required 42/41/42", r7, g7, b7);
        end
        checks++;
        if (ready7 !== 1'b1 || underflow7 !== 1'b0) begin
            errors++;
            $display("FAIL width7_ctrl: rdy=%b uf=%b required rdy=1 uf=0", ready7, underflow7);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({r, g, b} !== exp) begin
            errors++;
            $display("FAIL width6: rgb=%h required %h", {r, g, b}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic_doubling();
        test_backpressure();
        test_underflow();
        test_clear_race();
        test_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
